// File: rtl/jpeg_coef_buffer.sv
// jpeg_coef_buffer: double-buffered 8x8 coefficient block buffer.
// Collects sparse natural-order coefficients into one bank, zero-fills the
// unwritten positions and replays each complete block as a dense 64-beat
// valid/accept stream while the other bank fills.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   img_start_i            flush all buffered blocks and the output stream
//   inport_*               sparse coefficient input (valid/data/idx/id/eob)
//   inport_accept_o        current write bank can take a block
//   outport_*              dense output stream (valid/data/idx/id/last)
//   outport_accept_i       downstream takes the current beat
//
// Option: define JPEG_COEF_COL_ORDER_EN to read each block column-major
// (positions 0,8,16,...,56,1,9,...); default is raster order.
`timescale 1ns/1ps

module jpeg_coef_buffer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        img_start_i,
    input  logic        inport_valid_i,
    input  logic [15:0] inport_data_i,
    input  logic [5:0]  inport_idx_i,
    input  logic [31:0] inport_id_i,
    input  logic        inport_eob_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [15:0] outport_data_o,
    output logic [5:0]  outport_idx_o,
    output logic [31:0] outport_id_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] mem_q  [2][64];
    logic [63:0] mask_q [2];
    logic [31:0] id_q   [2];
    logic [1:0]  full_q;
    logic        wr_bank_q;
    logic        rd_bank_q;
    logic [5:0]  rd_cnt_q, cnt_d;

    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic [5:0]  out_idx_q;
    logic [31:0] out_id_q;
    logic        out_last_q;

    logic        wr_en;
    logic        out_ready;
    logic        load;
    logic        release_blk;
    logic        drop_valid;
    logic        ld_bank;
    logic [5:0]  ld_cnt;
    logic [5:0]  ld_pos;
    logic [15:0] ld_data;

    // Beats into a full bank are dropped; img_start_i discards same-cycle beats.
    assign wr_en     = inport_valid_i && !full_q[wr_bank_q] && !img_start_i;
    assign out_ready = !out_valid_q || outport_accept_i;

`ifdef JPEG_COEF_COL_ORDER_EN
    assign ld_pos = {ld_cnt[2:0], ld_cnt[5:3]};
`else
    assign ld_pos = ld_cnt;
`endif

    assign ld_data = mask_q[ld_bank][ld_pos] ? mem_q[ld_bank][ld_pos] : 16'd0;

    // IDLE loads beat 0 directly so the first beat appears one cycle after
    // the full flag. DRAIN waits for the last beat's accept; if the other
    // bank is already full its beat 0 is loaded on the same edge (no bubble).
    always_comb begin
        state_d     = state_q;
        cnt_d       = rd_cnt_q;
        load        = 1'b0;
        release_blk = 1'b0;
        drop_valid  = 1'b0;
        ld_bank     = rd_bank_q;
        ld_cnt      = rd_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load    = 1'b1;
                    ld_cnt  = 6'd0;
                    cnt_d   = 6'd1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    load  = 1'b1;
                    cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_q == 6'd63) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && outport_accept_i) begin
                    release_blk = 1'b1;
                    cnt_d       = 6'd0;
                    if (full_q[~rd_bank_q]) begin
                        load    = 1'b1;
                        ld_bank = ~rd_bank_q;
                        ld_cnt  = 6'd0;
                        cnt_d   = 6'd1;
                        state_d = STREAM;
                    end else begin
                        drop_valid = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || img_start_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Coefficient storage needs no reset: the masks gate every read.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en) begin
            mem_q[wr_bank_q][inport_idx_i] <= inport_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_q[0]   <= '0;
            mask_q[1]   <= '0;
            id_q[0]     <= '0;
            id_q[1]     <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
        end else if (img_start_i) begin
            mask_q[0]   <= '0;
            mask_q[1]   <= '0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_cnt_q <= cnt_d;
            // A write only targets a non-full bank and a release only a full
            // one, so these never touch the same bank in one cycle.
            if (wr_en) begin
                mask_q[wr_bank_q][inport_idx_i] <= 1'b1;
                if (inport_eob_i) begin
                    id_q[wr_bank_q]   <= inport_id_i;
                    full_q[wr_bank_q] <= 1'b1;
                    wr_bank_q         <= ~wr_bank_q;
                end
            end
            if (release_blk) begin
                mask_q[rd_bank_q] <= '0;
                full_q[rd_bank_q] <= 1'b0;
                rd_bank_q         <= ~rd_bank_q;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ld_data;
                out_idx_q   <= ld_pos;
                out_id_q    <= id_q[ld_bank];
                out_last_q  <= (ld_cnt == 6'd63);
            end else if (drop_valid) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign inport_accept_o = !full_q[wr_bank_q];
    assign outport_valid_o = out_valid_q;
    assign outport_data_o  = out_data_q;
    assign outport_idx_o   = out_idx_q;
    assign outport_id_o    = out_id_q;
    assign outport_last_o  = out_last_q;

endmodule
